i2c_flash_master: RTL and testbench

- I2C bus initiator that drives transactions into the flash-side I2C controller (the responder on SCL/SDA).
- Converts a parallel command (read or write, 16-bit flash address, 8-bit data) into START, device-ID, address MSB, address LSB and data phases, then STOP.
- Generates SCL, drives SDA open-drain, checks every responder ACK and returns read data.
- Sits between the host/test logic and the SCL/SDA pins.

---
 rtl/i2c_flash_master_if.sv | 30 +++
 rtl/i2c_flash_master.sv | 184 ++++++++++++++++++
 tb/tb_i2c_flash_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_flash_master_if.sv
// i2c_flash_master_if: host command/status and I2C pin bundle for i2c_flash_master.
//   go, wr, addr, wData : command strobe and operands (host -> master)
//   busy, done, ackErr  : transaction status (master -> host)
//   rData               : byte returned by the last successful read
//   scl, sdaOe          : bus clock and open-drain SDA pull-down enable
//   sdaIn               : sampled SDA line level
// The master modport is the view taken by i2c_flash_master; slave is the host/pin side.
interface i2c_flash_master_if;
  logic        go;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  wData;
  logic        busy;
  logic        done;
  logic        ackErr;
  logic [7:0]  rData;
  logic        scl;
  logic        sdaOe;
  logic        sdaIn;

  modport master (
    input  go, wr, addr, wData, sdaIn,
    output busy, done, ackErr, rData, scl, sdaOe
  );

  modport slave (
    output go, wr, addr, wData, sdaIn,
    input  busy, done, ackErr, rData, scl, sdaOe
  );
endinterface

// File: rtl/i2c_flash_master.sv
// i2c_flash_master: I2C initiator that turns a parallel flash command into a bus transaction.
//   Write: START, {DEV_ADDR,0}, ADDR[15:8], ADDR[7:0], WDATA, STOP (responder ACK after each byte).
//   Read : START, {DEV_ADDR,0}, ADDR[15:8], ADDR[7:0], repeated START, {DEV_ADDR,1},
//          8 data bits in, master NACK, STOP.
// Ports:
//   clk  - system clock, rising-edge
//   rst  - asynchronous active-high reset; abandons any transfer without STOP or DONE
//   bus  - i2c_flash_master_if.master (command, status, read data, SCL/SDA pins)
// Each bus bit spans four quarters of CLK_DIV cycles each. All bus pins are registered.
module i2c_flash_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [6:0]  DEV_ADDR = 7'b1010000
) (
  input logic                clk,
  input logic                rst,
  i2c_flash_master_if.master bus
);

  localparam int unsigned     DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  typedef enum logic [4:0] {
    StIdle, StStart, StDevW, StAckDw, StAmsb, StAckAm, StAlsb, StAckAl,
    StWbyte, StAckWd, StRstart, StDevR, StAckDr, StRbyte, StMnack, StStop, StDone
  } state_e;

  state_e          stateQ, stateD;
  logic [DivW-1:0] divCntQ;
  logic [1:0]      qCntQ, qCntD;
  logic [2:0]      bitCntQ, bitCntD;
  logic            wrQ;
  logic [15:0]     addrQ;
  logic [7:0]      wDataQ;
  logic [7:0]      rxShiftQ;
  logic            busyQ, doneQ, ackErrQ;
  logic [7:0]      rDataQ;
  logic            sclQ, sdaOeQ;

  logic            tick, bitEnd, lastBit, isAck;
  logic [7:0]      txByte;
  logic            txBit, sclD, sdaOeD;

  assign bus.busy   = busyQ;
  assign bus.done   = doneQ;
  assign bus.ackErr = ackErrQ;
  assign bus.rData  = rDataQ;
  assign bus.scl    = sclQ;
  assign bus.sdaOe  = sdaOeQ;

  // Next bit/quarter position and the pin levels for the quarter about to begin.
  always_comb begin
    tick    = (divCntQ == DivMax);
    bitEnd  = tick && (qCntQ == 2'd3);
    lastBit = (bitCntQ == 3'd7);
    isAck   = stateQ inside {StAckDw, StAckAm, StAckAl, StAckWd, StAckDr};
    qCntD   = qCntQ + 2'd1;
    stateD  = stateQ;
    bitCntD = bitCntQ;

    if (bitEnd) begin
      unique case (stateQ)
        StStart:  stateD = StDevW;
        StDevW:   stateD = lastBit ? StAckDw : StDevW;
        StAckDw:  stateD = ackErrQ ? StStop : StAmsb;
        StAmsb:   stateD = lastBit ? StAckAm : StAmsb;
        StAckAm:  stateD = ackErrQ ? StStop : StAlsb;
        StAlsb:   stateD = lastBit ? StAckAl : StAlsb;
        StAckAl:  stateD = ackErrQ ? StStop : (wrQ ? StWbyte : StRstart);
        StWbyte:  stateD = lastBit ? StAckWd : StWbyte;
        StAckWd:  stateD = StStop;
        StRstart: stateD = StDevR;
        StDevR:   stateD = lastBit ? StAckDr : StDevR;
        StAckDr:  stateD = ackErrQ ? StStop : StRbyte;
        StRbyte:  stateD = lastBit ? StMnack : StRbyte;
        StMnack:  stateD = StStop;
        StStop:   stateD = StDone;
        default:  stateD = stateQ;
      endcase
      // Bit index wraps 7 -> 0 on leaving a byte, so it is already 0 for every 1-bit phase.
      if (stateQ inside {StDevW, StAmsb, StAlsb, StWbyte, StDevR, StRbyte}) begin
        bitCntD = bitCntQ + 3'd1;
      end
    end

    // All-ones keeps SDA released for ACK, read-data and master-NACK bits.
    unique case (stateD)
      StDevW:  txByte = {DEV_ADDR, 1'b0};
      StDevR:  txByte = {DEV_ADDR, 1'b1};
      StAmsb:  txByte = addrQ[15:8];
      StAlsb:  txByte = addrQ[7:0];
      StWbyte: txByte = wDataQ;
      default: txByte = 8'hFF;
    endcase
    txBit = txByte[3'd7 - bitCntD];

    unique case (stateD)
      StStart, StRstart: begin
        // SDA falls in Q1 while SCL is still high, SCL drops from Q2.
        sclD   = ~qCntD[1];
        sdaOeD = (qCntD != 2'd0);
      end
      StStop: begin
        // SDA rises in Q2 while SCL is high.
        sclD   = (qCntD != 2'd0);
        sdaOeD = ~qCntD[1];
      end
      StIdle, StDone: begin
        sclD   = 1'b1;
        sdaOeD = 1'b0;
      end
      default: begin
        sclD   = qCntD[0] ^ qCntD[1];
        sdaOeD = ~txBit;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ   <= StIdle;
      divCntQ  <= '0;
      qCntQ    <= '0;
      bitCntQ  <= '0;
      wrQ      <= 1'b0;
      addrQ    <= '0;
      wDataQ   <= '0;
      rxShiftQ <= '0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      ackErrQ  <= 1'b0;
      rDataQ   <= '0;
      sclQ     <= 1'b1;
      sdaOeQ   <= 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          doneQ <= 1'b0;
          // The DONE cycle is already spent in IDLE, so a GO there must be rejected.
          if (bus.go && !doneQ) begin
            stateQ  <= StStart;
            divCntQ <= '0;
            qCntQ   <= '0;
            bitCntQ <= '0;
            wrQ     <= bus.wr;
            addrQ   <= bus.addr;
            wDataQ  <= bus.wData;
            busyQ   <= 1'b1;
            ackErrQ <= 1'b0;
            sclQ    <= 1'b1;
            sdaOeQ  <= 1'b0;
          end
        end
        StDone: begin
          stateQ <= StIdle;
          doneQ  <= 1'b1;
          busyQ  <= 1'b0;
          if (!wrQ && !ackErrQ) begin
            rDataQ <= rxShiftQ;
          end
        end
        default: begin
          divCntQ <= tick ? '0 : divCntQ + DivW'(1);
          if (tick) begin
            stateQ  <= stateD;
            qCntQ   <= qCntD;
            bitCntQ <= bitCntD;
            sclQ    <= sclD;
            sdaOeQ  <= sdaOeD;
            // End of Q2: SCL has been high for a full quarter.
            if (qCntQ == 2'd2) begin
              if (isAck && bus.sdaIn) begin
                ackErrQ <= 1'b1;
              end
              if (stateQ == StRbyte) begin
                rxShiftQ <= {rxShiftQ[6:0], bus.sdaIn};
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_flash_master.sv
module tb_i2c_flash_master;

  logic        clk, rst, sel, go, wr;
  logic [15:0] addr;
  logic [7:0]  wData;

  i2c_flash_master_if bus0 ();
  i2c_flash_master_if bus1 ();

  i2c_flash_master #(.CLK_DIV(4), .DEV_ADDR(7'b1010000)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  i2c_flash_master #(.CLK_DIV(1), .DEV_ADDR(7'b1010000)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Shared responder: sel picks which master owns the bus.
  logic sclSel, mOe, slvOe, sdaLine;
  assign sclSel  = sel ? bus1.scl : bus0.scl;
  assign mOe     = sel ? bus1.sdaOe : bus0.sdaOe;
  assign sdaLine = !(mOe || slvOe);

  assign bus0.go    = go & ~sel;
  assign bus1.go    = go & sel;
  assign bus0.wr    = wr;
  assign bus1.wr    = wr;
  assign bus0.addr  = addr;
  assign bus1.addr  = addr;
  assign bus0.wData = wData;
  assign bus1.wData = wData;
  assign bus0.sdaIn = sdaLine;
  assign bus1.sdaIn = sdaLine;

  logic       doneS, busyS, errS;
  logic [7:0] rdS;
  assign doneS = sel ? bus1.done : bus0.done;
  assign busyS = sel ? bus1.busy : bus0.busy;
  assign errS  = sel ? bus1.ackErr : bus0.ackErr;
  assign rdS   = sel ? bus1.rData : bus0.rData;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural flash responder, sampled on the falling CLK edge.
  int         nackByte = -1;
  logic [7:0] rdByte = 8'h00;
  logic [7:0] rxLog[$];
  int         startCnt = 0, stopCnt = 0;
  logic       prevScl, prevSda, txMode, addrByte;
  logic [3:0] sBit;
  logic [7:0] sShift;

  always @(negedge clk) begin
    if (rst) begin
      prevScl  <= 1'b1;
      prevSda  <= 1'b1;
      txMode   <= 1'b0;
      addrByte <= 1'b0;
      slvOe    <= 1'b0;
      sBit     <= 4'd0;
      sShift   <= 8'h00;
    end else begin
      prevScl <= sclSel;
      prevSda <= sdaLine;
      if (prevScl && sclSel && prevSda && !sdaLine) begin
        startCnt <= startCnt + 1;
        sBit     <= 4'd0;
        txMode   <= 1'b0;
        slvOe    <= 1'b0;
        addrByte <= 1'b1;
      end else if (prevScl && sclSel && !prevSda && sdaLine) begin
        stopCnt <= stopCnt + 1;
        txMode  <= 1'b0;
        slvOe   <= 1'b0;
      end else if (!prevScl && sclSel) begin
        if (sBit < 4'd8) begin
          sShift <= {sShift[6:0], sdaLine};
          sBit   <= sBit + 4'd1;
        end else begin
          sBit <= 4'd0;
          if (txMode && sdaLine) txMode <= 1'b0;  // master NACK ends our send
        end
      end else if (prevScl && !sclSel) begin
        if (sBit == 4'd8) begin
          if (txMode) begin
            slvOe <= 1'b0;
          end else begin
            slvOe <= (rxLog.size() != nackByte);
            if (addrByte && sShift[0] && rxLog.size() != nackByte) txMode <= 1'b1;
            addrByte <= 1'b0;
            rxLog.push_back(sShift);
          end
        end else if (txMode) begin
          slvOe <= !rdByte[3'd7 - sBit[2:0]];
        end else begin
          slvOe <= 1'b0;
        end
      end
    end
  end

  int nTests = 0, nFail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        s;
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  rd;
    int          nack;
    int          cyc;
    logic        err;
    logic [7:0]  rdat;
    int          nBytes;
    logic [31:0] bytes;  // first byte on the bus in [31:24]
    int          starts;
  } vec_t;

  vec_t vecs[9];
  int   startBase, stopBase;

  task automatic runTxn(input logic s, input logic w, input logic [15:0] a, input logic [7:0] d,
                        output int cyc);
    @(posedge clk);
    #1;
    rxLog.delete();
    startBase = startCnt;
    stopBase  = stopCnt;
    sel = s; wr = w; addr = a; wData = d; go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0; wr = ~w; addr = ~a; wData = ~d;
    cyc = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (doneS) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic checkBytes(input string tag, input int n, input logic [31:0] bytes);
    logic [7:0] got;
    check({tag, " byte count"}, rxLog.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < rxLog.size()) ? rxLog[i] : 8'hxx;
      check($sformatf("%s byte%0d", tag, i), got, bytes[31-8*i -: 8]);
    end
  endtask

  initial begin
    int cyc, doneSeen;
    vec_t v;
    rst = 1'b1; sel = 1'b0; go = 1'b0; wr = 1'b0; addr = '0; wData = '0;

    vecs[0] = '{s:0, w:1, a:16'h1234, d:8'hA5, rd:8'h00, nack:-1, cyc:609, err:0, rdat:8'h00,
                nBytes:4, bytes:32'hA01234A5, starts:1};
    vecs[1] = '{s:0, w:0, a:16'h5555, d:8'h00, rd:8'h3C, nack:-1, cyc:769, err:0, rdat:8'h3C,
                nBytes:4, bytes:32'hA05555A1, starts:2};
    vecs[2] = '{s:0, w:0, a:16'h0000, d:8'h00, rd:8'h77, nack:0, cyc:177, err:1, rdat:8'h3C,
                nBytes:1, bytes:32'hA0000000, starts:1};
    vecs[3] = '{s:0, w:1, a:16'h00FF, d:8'h5A, rd:8'h00, nack:2, cyc:465, err:1, rdat:8'h3C,
                nBytes:3, bytes:32'hA000FF00, starts:1};
    vecs[4] = '{s:0, w:0, a:16'hABCD, d:8'h00, rd:8'h81, nack:-1, cyc:769, err:0, rdat:8'h81,
                nBytes:4, bytes:32'hA0ABCDA1, starts:2};
    vecs[5] = '{s:0, w:0, a:16'h0102, d:8'h00, rd:8'h55, nack:3, cyc:625, err:1, rdat:8'h81,
                nBytes:4, bytes:32'hA00102A1, starts:2};
    vecs[6] = '{s:0, w:1, a:16'hFFFF, d:8'h00, rd:8'h00, nack:-1, cyc:609, err:0, rdat:8'h81,
                nBytes:4, bytes:32'hA0FFFF00, starts:1};
    vecs[7] = '{s:1, w:1, a:16'h1234, d:8'hA5, rd:8'h00, nack:-1, cyc:153, err:0, rdat:8'h00,
                nBytes:4, bytes:32'hA01234A5, starts:1};
    vecs[8] = '{s:1, w:0, a:16'h5555, d:8'h00, rd:8'h3C, nack:-1, cyc:193, err:0, rdat:8'h3C,
                nBytes:4, bytes:32'hA05555A1, starts:2};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", bus0.busy, 0);
    check("reset done", bus0.done, 0);
    check("reset ackErr", bus0.ackErr, 0);
    check("reset rData", bus0.rData, 8'h00);
    check("reset scl", bus0.scl, 1);
    check("reset sdaOe", bus0.sdaOe, 0);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) begin
      v = vecs[k];
      nackByte = v.nack;
      rdByte   = v.rd;
      runTxn(v.s, v.w, v.a, v.d, cyc);
      check($sformatf("v%0d done cycle", k), cyc, v.cyc);
      check($sformatf("v%0d ackErr", k), errS, v.err);
      check($sformatf("v%0d rData", k), rdS, v.rdat);
      check($sformatf("v%0d busy at done", k), busyS, 0);
      check($sformatf("v%0d starts", k), startCnt - startBase, v.starts);
      check($sformatf("v%0d stops", k), stopCnt - stopBase, 1);
      checkBytes($sformatf("v%0d", k), v.nBytes, v.bytes);
    end

    // GO while busy is ignored; GO in the DONE cycle is ignored.
    nackByte = -1;
    @(posedge clk);
    #1;
    rxLog.delete();
    sel = 1'b0; wr = 1'b1; addr = 16'h1234; wData = 8'hA5; go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) check("busy after go", bus0.busy, 1);
      if (i == 100) begin
        go = 1'b1; wr = 1'b0; wData = 8'hFF;
      end
      if (i == 101) go = 1'b0;
      if (bus0.done) begin
        cyc = i;
        break;
      end
    end
    check("busy-go done cycle", cyc, 609);
    checkBytes("busy-go", 4, 32'hA01234A5);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    check("go at done ignored", bus0.busy, 0);

    // Reset in the address-MSB phase.
    @(posedge clk);
    #1;
    wr = 1'b1; addr = 16'h1234; wData = 8'hA5; go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    doneSeen = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (bus0.done) doneSeen++;
    end
    rst = 1'b1;
    #1;
    check("mid reset scl", bus0.scl, 1);
    check("mid reset sdaOe", bus0.sdaOe, 0);
    check("mid reset busy", bus0.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus0.done) doneSeen++;
    end
    check("mid reset no done", doneSeen, 0);
    runTxn(1'b0, 1'b1, 16'h1234, 8'hA5, cyc);
    check("after reset done cycle", cyc, 609);
    check("after reset ackErr", bus0.ackErr, 0);
    checkBytes("after reset", 4, 32'hA01234A5);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
